// File: rtl/alu_result_stage_if.sv
// Bus between the ALU, the result stage and the downstream consumer.
// master: the side that drives ALU results and consumes the head entry (ALU + consumer).
// slave:  the result stage itself.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 6
);
    // ALU -> stage
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;
    logic             a_msb;
    logic             b_msb;
    // stage -> consumer
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    modport master (
        output in_valid, ALUOp, Result, CarryOut, a_msb, b_msb, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, ALUOp, Result, CarryOut, a_msb, b_msb, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ripple ALU: small FIFO of results with flags,
// a carry register for chained multi-word add/sub, and a saturating op counter.
// Optional feature: define ALU_OVF_FLAG_EN to store and drive a signed-overflow flag.
module alu_result_stage #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_result_stage_if.slave   bus,
    output logic                carry_next,
    output logic [7:0]          op_count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic [WIDTH-1:0] r_mem_result [DEPTH];
    logic             r_mem_carry  [DEPTH];
    logic             r_mem_zero   [DEPTH];
    logic             r_mem_neg    [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_carry_next;
    logic [7:0]       r_op_count;

    logic w_push;
    logic w_pop;
    logic w_in_ready;
    logic w_out_valid;
    logic w_is_arith;
    logic w_ovf;

    // No bypass: a full FIFO refuses input even if the head leaves this cycle.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_is_arith  = (bus.ALUOp == OP_ADD) || (bus.ALUOp == OP_SUB);

`ifdef ALU_OVF_FLAG_EN
    logic r_mem_ovf [DEPTH];

    // Signed overflow from operand and result sign bits; only add/sub can overflow.
    always_comb begin
        w_ovf = 1'b0;
        if (bus.ALUOp == OP_ADD) begin
            w_ovf = (bus.a_msb == bus.b_msb) && (bus.Result[WIDTH-1] != bus.a_msb);
        end else if (bus.ALUOp == OP_SUB) begin
            w_ovf = (bus.a_msb != bus.b_msb) && (bus.Result[WIDTH-1] != bus.a_msb);
        end
    end

    // Overflow storage alongside the other per-entry flags.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_ovf[r_wptr] <= w_ovf;
        end
    end
`else
    logic w_unused_msb;
    assign w_unused_msb = bus.a_msb ^ bus.b_msb;
    assign w_ovf        = 1'b0;
`endif

    // Entry storage; contents are don't-care while not counted as valid, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_result[r_wptr] <= bus.Result;
            r_mem_carry[r_wptr]  <= bus.CarryOut;
            r_mem_zero[r_wptr]   <= ~|bus.Result;
            r_mem_neg[r_wptr]    <= bus.Result[WIDTH-1];
        end
    end

    // Pointers, occupancy, carry chain and op counter; flush beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_carry_next <= 1'b0;
            r_op_count   <= '0;
        end else if (flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_carry_next <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
                if (w_is_arith) begin
                    r_carry_next <= bus.CarryOut;
                end
                if (r_op_count != 8'hFF) begin
                    r_op_count <= r_op_count + 8'd1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs read zero while the FIFO is empty.
    always_comb begin
        bus.out_result = '0;
        bus.out_carry  = 1'b0;
        bus.out_zero   = 1'b0;
        bus.out_neg    = 1'b0;
        bus.out_ovf    = 1'b0;
        if (w_out_valid) begin
            bus.out_result = r_mem_result[r_rptr];
            bus.out_carry  = r_mem_carry[r_rptr];
            bus.out_zero   = r_mem_zero[r_rptr];
            bus.out_neg    = r_mem_neg[r_rptr];
`ifdef ALU_OVF_FLAG_EN
            bus.out_ovf    = r_mem_ovf[r_rptr];
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign carry_next    = r_carry_next;
    assign op_count      = r_op_count;
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// compared against a queue-based reference model. Honours ALU_OVF_FLAG_EN.
module tb_alu_result_stage;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned DEPTH = 2;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       carry_next;
    logic [7:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    entry_t mq[$];
    logic   m_carry = 1'b0;
    int     m_count = 0;

    logic [3:0] ops [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .carry_next (carry_next),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input logic [3:0] op, input logic [WIDTH-1:0] res,
                                  input logic co, input logic am, input logic bm);
        entry_t e;
        int     sres;
        e.result = res;
        e.carry  = co;
        e.zero   = (int'(res) == 0);
        e.neg    = (int'(res) >= (1 << (WIDTH - 1)));
        e.ovf    = 1'b0;
`ifdef ALU_OVF_FLAG_EN
        // Result sign differs from a's sign while the operands agree (add) or disagree (sub).
        sres = e.neg ? 1 : 0;
        if (op == OP_ADD) e.ovf = (am == bm) && (sres != int'(am));
        if (op == OP_SUB) e.ovf = (am != bm) && (sres != int'(am));
`else
        sres = 0;
`endif
        return e;
    endfunction

    task automatic check_state(input string ctx);
        entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check({ctx, ".out_valid"},  32'(bus.out_valid),  32'(mq.size() != 0));
        check({ctx, ".in_ready"},   32'(bus.in_ready),   32'(mq.size() < DEPTH));
        check({ctx, ".out_result"}, 32'(bus.out_result), 32'(h.result));
        check({ctx, ".out_carry"},  32'(bus.out_carry),  32'(h.carry));
        check({ctx, ".out_zero"},   32'(bus.out_zero),   32'(h.zero));
        check({ctx, ".out_neg"},    32'(bus.out_neg),    32'(h.neg));
        check({ctx, ".out_ovf"},    32'(bus.out_ovf),    32'(h.ovf));
        check({ctx, ".carry_next"}, 32'(carry_next),     32'(m_carry));
        check({ctx, ".op_count"},   32'(op_count),       32'(m_count));
    endtask

    // One clock: drive inputs, check current state, advance DUT and model together.
    task automatic step(input logic iv, input logic [3:0] op, input logic [WIDTH-1:0] res,
                        input logic co, input logic am, input logic bm,
                        input logic ordy, input logic fl, input string ctx);
        bit push;
        bit pop;
        bus.in_valid  = iv;
        bus.ALUOp     = op;
        bus.Result    = res;
        bus.CarryOut  = co;
        bus.a_msb     = am;
        bus.b_msb     = bm;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check_state(ctx);
        push = iv && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_carry = 1'b0;
            m_count = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mk(op, res, co, am, bm));
                if (op == OP_ADD || op == OP_SUB) m_carry = co;
                if (m_count < 255) m_count++;
            end
        end
    endtask

    task automatic idle(input logic ordy, input string ctx);
        step(1'b0, OP_AND, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, ctx);
    endtask

    task automatic do_flush(input string ctx);
        step(1'b0, OP_AND, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ctx);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ALUOp     = OP_AND;
        bus.Result    = '0;
        bus.CarryOut  = 1'b0;
        bus.a_msb     = 1'b0;
        bus.b_msb     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check_state("reset");
        check("reset.op_count", 32'(op_count), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: zero-result ADD with carry appears next cycle
        step(1'b1, OP_ADD, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t1.push");
        #1;
        check("t1.out_valid", 32'(bus.out_valid), 32'd1);
        check("t1.out_zero", 32'(bus.out_zero), 32'd1);
        check("t1.out_carry", 32'(bus.out_carry), 32'd1);
        check("t1.carry_next", 32'(carry_next), 32'd1);
        check("t1.op_count", 32'(op_count), 32'd1);
        idle(1'b1, "t1.drain");

        // 2: third push refused when full; drain in order
        do_flush("t2.flush");
        step(1'b1, OP_OR, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2.p0");
        step(1'b1, OP_OR, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2.p1");
        #1;
        check("t2.in_ready_full", 32'(bus.in_ready), 32'd0);
        step(1'b1, OP_OR, 6'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2.p2");
        #1;
        check("t2.head0", 32'(bus.out_result), 32'h11);
        check("t2.op_count", 32'(op_count), 32'd2);
        idle(1'b1, "t2.d0");
        #1;
        check("t2.head1", 32'(bus.out_result), 32'h22);
        idle(1'b1, "t2.d1");
        #1;
        check("t2.empty", 32'(bus.out_valid), 32'd0);

        // 3: full + in_valid + out_ready -> pop only
        step(1'b1, OP_NOR, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3.p0");
        step(1'b1, OP_NOR, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3.p1");
        step(1'b1, OP_NOR, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.both");
        #1;
        check("t3.in_ready", 32'(bus.in_ready), 32'd1);
        check("t3.head", 32'(bus.out_result), 32'h2A);
        idle(1'b1, "t3.d0");
        idle(1'b1, "t3.d1");

        // 4: ADD overflow case
        do_flush("t4.flush");
        step(1'b1, OP_ADD, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4.push");
        #1;
        check("t4.out_neg", 32'(bus.out_neg), 32'd1);
`ifdef ALU_OVF_FLAG_EN
        check("t4.out_ovf", 32'(bus.out_ovf), 32'd1);
`else
        check("t4.out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
        idle(1'b1, "t4.drain");

        // 5: carry held across a logical op, cleared by flush
        step(1'b1, OP_ADD, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5.add");
        step(1'b1, OP_AND, 6'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5.and");
        #1;
        check("t5.carry_held", 32'(carry_next), 32'd1);
        step(1'b1, OP_SUB, 6'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t5.flush");
        #1;
        check("t5.carry_clr", 32'(carry_next), 32'd0);
        check("t5.out_valid", 32'(bus.out_valid), 32'd0);
        check("t5.in_ready", 32'(bus.in_ready), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 250; i++) begin
            step(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)],
                 WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rnd");
        end

        // 6: counter saturation, then asynchronous reset mid-stream
        do_flush("t6.flush");
        for (int i = 0; i < 300; i++) begin
            step(1'b1, OP_SUB, WIDTH'(i), 1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0,
                 "t6.stream");
        end
        #1;
        check("t6.op_count_sat", 32'(op_count), 32'd255);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_carry = 1'b0;
        m_count = 0;
        check_state("t6.async_rst");
        check("t6.rst_op_count", 32'(op_count), 32'd0);
        check("t6.rst_carry", 32'(carry_next), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1, "t6.post");
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
